// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: widths, reset PC,
// counter sizing, buffer entry type and PC arithmetic helpers.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Width of the outstanding/drop counters. Dropped requests can pile up
  // across back-to-back redirects, so this is sized well above BUF_DEPTH.
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a fetch address; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  // Force a target address onto an instruction word boundary.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory, the branch
// unit (redirect) and decode. master = fetch unit side, slave = environment.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;

  modport master (
    output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction buffer of DEPTH {pc, instr} entries. Flush empties it
// and takes priority over push/pop; push at full is honoured only together
// with a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty && !flush;
  assign do_push_s = push && (!full || do_pop_s) && !flush;

  // Entry storage: write the incoming word at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(2*XLEN){1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping, flush returns to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, credit-limited request issue,
// redirect handling with in-flight response dropping, and a small buffer
// towards decode. Optional macro FETCH_PERF_EN adds a saturating count of
// cycles where decode was ready but no instruction was available.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0] perf_stall_cnt,
`endif
  fetch_if.master         bus
);

  localparam int FCW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0]  pc_r;          // next address to request
  logic [XLEN-1:0]  rsp_pc_r;      // fetch address of the next live response
  logic [CNT_W-1:0] outstanding_r; // every request not yet answered
  logic [CNT_W-1:0] drop_r;        // of those, how many are stale
  logic             run_r;         // low for the first edge after reset

  logic [CNT_W-1:0] live_s;
  logic [CNT_W-1:0] used_s;
  logic             req_valid_s;
  logic             fire_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [FCW-1:0]   count_s;
  fetch_entry_t     head_s;
  fetch_entry_t     push_entry_s;

  // Credits: live requests plus buffered words, net of this cycle's pop,
  // must leave room for one more. Stale requests hold no buffer space,
  // which lets the first post-redirect fetch go out immediately.
  assign live_s      = outstanding_r - drop_r;
  assign pop_s       = !empty_s && bus.out_ready;
  assign used_s      = live_s + CNT_W'(count_s) - CNT_W'(pop_s);
  assign req_valid_s = run_r && !bus.redirect_valid && (used_s < CNT_W'(BUF_DEPTH));
  assign fire_s      = req_valid_s && bus.imem_req_ready;

  // A response is kept only when nothing marks it stale.
  assign push_s = bus.imem_rsp_valid && !bus.redirect_valid &&
                  (drop_r == {CNT_W{1'b0}}) && (!full_s || pop_s);
  assign push_entry_s = '{pc: rsp_pc_r, instr: bus.imem_rsp_data};

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (bus.redirect_valid),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_addr      = pc_r;
  assign bus.out_valid      = !empty_s;
  assign bus.out_instr      = head_s.instr;
  assign bus.out_pc         = head_s.pc;
  assign bus.out_pc_plus4   = pc_next(head_s.pc);

  // PC, response address, outstanding and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= {CNT_W{1'b0}};
      drop_r        <= {CNT_W{1'b0}};
      run_r         <= 1'b0;
    end else begin
      run_r         <= 1'b1;
      outstanding_r <= outstanding_r + CNT_W'(fire_s) - CNT_W'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        pc_r     <= pc_align(bus.redirect_pc);
        rsp_pc_r <= pc_align(bus.redirect_pc);
        // Everything still in flight after this cycle is now stale.
        drop_r   <= outstanding_r - CNT_W'(bus.imem_rsp_valid);
      end else begin
        if (fire_s) pc_r <= pc_next(pc_r);
        if (push_s) rsp_pc_r <= pc_next(rsp_pc_r);
        if (bus.imem_rsp_valid && (drop_r != {CNT_W{1'b0}})) begin
          drop_r <= drop_r - CNT_W'(1);
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_stall_cnt_r;

  // Saturating count of cycles decode waited on an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_r <= {XLEN{1'b0}};
    end else if (bus.out_ready && empty_s && (perf_stall_cnt_r != {XLEN{1'b1}})) begin
      perf_stall_cnt_r <= perf_stall_cnt_r + XLEN'(1);
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory model answers requests in
// order after a chosen latency; a stream-level reference model (per-redirect
// epochs, expected PC sequence, buffered word count) checks every cycle.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus            (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // memory model
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mq_epoch[$];
  int          mem_lat = 1;
  int          rsp_pct = 100;

  // reference model
  int          epoch    = 0;
  int          buffered = 0;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_out_pc;
  logic [31:0] exp_perf;

  // what happened in the last stepped cycle
  logic        last_fire;
  logic [31:0] last_addr;
  logic        last_pop;
  logic [31:0] last_pop_pc;
  logic [31:0] last_pop_p4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (mq_epoch[i]) if (mq_epoch[i] == epoch) n++;
    return n;
  endfunction

  task automatic model_reset();
    mq_addr.delete(); mq_due.delete(); mq_epoch.delete();
    epoch++;
    buffered   = 0;
    exp_req_pc = RPC;
    exp_out_pc = RPC;
    exp_perf   = 32'h0000_0000;
    cyc        = 0;
  endtask

  task automatic apply_reset();
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One clock cycle: memory drives its response, outputs are compared with
  // the reference model, then both models advance across the rising edge.
  task automatic step();
    logic rsp_now;
    logic exp_ov, exp_pop, exp_rv, fire;
    int   live;
    rsp_now = (mq_addr.size() > 0) && (mq_due[0] <= cyc) && ($urandom_range(99) < rsp_pct);
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mem_word(mq_addr[0]) : $urandom();
    #1;
    exp_ov  = (buffered > 0);
    exp_pop = exp_ov && bus.out_ready;
    live    = live_count();
    exp_rv  = !bus.redirect_valid && ((live + buffered - (exp_pop ? 1 : 0)) < DEPTH);
    checks++;
    if (bus.out_valid !== exp_ov) begin
      errors++; $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, bus.out_valid, exp_ov);
    end
    checks++;
    if (bus.imem_req_valid !== exp_rv) begin
      errors++; $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, bus.imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (bus.imem_addr !== exp_req_pc) begin
        errors++; $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, bus.imem_addr, exp_req_pc);
      end
    end
    if (exp_ov) begin
      checks++;
      if (bus.out_pc !== exp_out_pc || bus.out_instr !== mem_word(exp_out_pc) ||
          bus.out_pc_plus4 !== exp_out_pc + 32'd4) begin
        errors++;
        $display("FAIL out_word cyc=%0d: got pc=%h instr=%h p4=%h expected pc=%h instr=%h p4=%h",
                 cyc, bus.out_pc, bus.out_instr, bus.out_pc_plus4,
                 exp_out_pc, mem_word(exp_out_pc), exp_out_pc + 32'd4);
      end
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_stall_cnt !== exp_perf) begin
      errors++; $display("FAIL perf_cnt cyc=%0d: got %0d expected %0d", cyc, perf_stall_cnt, exp_perf);
    end
`endif
    fire        = bus.imem_req_valid && bus.imem_req_ready;
    last_fire   = fire;
    last_addr   = bus.imem_addr;
    last_pop    = bus.out_valid && bus.out_ready && !bus.redirect_valid;
    last_pop_pc = bus.out_pc;
    last_pop_p4 = bus.out_pc_plus4;
    if (bus.out_ready && !exp_ov && exp_perf != 32'hFFFF_FFFF) exp_perf++;
    if (rsp_now) begin
      if (mq_epoch[0] == epoch && !bus.redirect_valid) buffered++;
      void'(mq_addr.pop_front()); void'(mq_due.pop_front()); void'(mq_epoch.pop_front());
    end
    if (fire) begin
      mq_addr.push_back(bus.imem_addr);
      mq_due.push_back(cyc + mem_lat);
      mq_epoch.push_back(epoch);
    end
    if (bus.redirect_valid) begin
      epoch++;
      buffered   = 0;
      exp_req_pc = {bus.redirect_pc[31:2], 2'b00};
      exp_out_pc = exp_req_pc;
    end else begin
      if (exp_pop) begin buffered--; exp_out_pc += 32'd4; end
      if (exp_rv && bus.imem_req_ready) exp_req_pc += 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.imem_rsp_data = 32'h0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RPC) begin
      errors++; $display("FAIL release_req: got valid=%b addr=%h expected valid=1 addr=%h", bus.imem_req_valid, bus.imem_addr, RPC);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] fa[8];
    logic        ff[8], pp[8];
    logic [31:0] pa[8];
    apply_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; mem_lat = 1; rsp_pct = 100;
    for (int i = 0; i < 8; i++) begin
      step();
      ff[i] = last_fire; fa[i] = last_addr; pp[i] = last_pop; pa[i] = last_pop_pc;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ff[i] !== 1'b1 || fa[i] !== RPC + 32'(4*i)) begin
        errors++; $display("FAIL stream_req%0d: got fire=%b addr=%h expected fire=1 addr=%h", i, ff[i], fa[i], RPC + 32'(4*i));
      end
      checks++;
      if (pp[i+2] !== 1'b1 || pa[i+2] !== RPC + 32'(4*i)) begin
        errors++; $display("FAIL stream_out%0d: got pop=%b pc=%h expected pop=1 pc=%h", i, pp[i+2], pa[i+2], RPC + 32'(4*i));
      end
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    apply_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b0; mem_lat = 1; rsp_pct = 100;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_fire) fires++;
    end
    #1;
    checks++;
    if (fires != DEPTH) begin errors++; $display("FAIL bp_fires: got %0d expected %0d", fires, DEPTH); end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", bus.imem_req_valid); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC || bus.out_instr !== mem_word(RPC)) begin
      errors++; $display("FAIL bp_hold: got valid=%b pc=%h instr=%h expected 1 %h %h", bus.out_valid, bus.out_pc, bus.out_instr, RPC, mem_word(RPC));
    end
    bus.out_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_redirect();
    logic seen = 1'b0;
    apply_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; mem_lat = 3; rsp_pct = 100;
    for (int i = 0; i < 8 && live_count() < 2; i++) step();
    checks++;
    if (live_count() != 2) begin errors++; $display("FAIL redir_setup: got %0d outstanding expected 2", live_count()); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102;
    step();
    bus.redirect_valid = 1'b0;
    step();
    checks++;
    if (last_fire !== 1'b1 || last_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL redir_req: got fire=%b addr=%h expected fire=1 addr=00000100", last_fire, last_addr);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus.out_valid) seen = 1'b1; else step();
    end
    checks++;
    if (!seen || bus.out_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL redir_out: got seen=%b pc=%h expected seen=1 pc=00000100", seen, bus.out_pc);
    end
    mem_lat = 1;
    repeat (8) step();
  endtask

  task automatic test_ready_stall();
    apply_reset();
    bus.imem_req_ready = 1'b0; bus.out_ready = 1'b1; mem_lat = 1; rsp_pct = 100;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (last_addr !== RPC) begin errors++; $display("FAIL stall_addr%0d: got %h expected %h", i, last_addr, RPC); end
    end
    bus.imem_req_ready = 1'b1;
    step();
    checks++;
    if (last_fire !== 1'b1 || last_addr !== RPC) begin
      errors++; $display("FAIL stall_fire: got fire=%b addr=%h expected fire=1 addr=%h", last_fire, last_addr, RPC);
    end
    bus.imem_req_ready = 1'b0;
    #1;
    checks++;
    if (bus.imem_addr !== RPC + 32'd4) begin
      errors++; $display("FAIL stall_adv: got %h expected %h", bus.imem_addr, RPC + 32'd4);
    end
    repeat (4) step();
  endtask

  task automatic test_wrap();
    logic        found = 1'b0;
    logic [31:0] p4 = 32'hDEAD_BEEF;
    logic [31:0] second = 32'hDEAD_BEEF;
    int          nf = 0;
    apply_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; mem_lat = 1; rsp_pct = 100;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_fire) begin nf++; if (nf == 2) second = last_addr; end
      if (last_pop && last_pop_pc == 32'hFFFF_FFFC && !found) begin found = 1'b1; p4 = last_pop_p4; end
    end
    checks++;
    if (second !== 32'h0000_0000) begin errors++; $display("FAIL wrap_req: got %h expected 00000000", second); end
    checks++;
    if (!found || p4 !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_p4: got found=%b p4=%h expected found=1 p4=00000000", found, p4);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; mem_lat = 1; rsp_pct = 100;
    repeat (2) step();
    bus.out_ready = 1'b0;
    repeat (5) step();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got out_valid=%b expected 1", bus.out_valid); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got out_valid=%b req_valid=%b expected 0 0", bus.out_valid, bus.imem_req_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL mid_perf: got %0d expected 0", perf_stall_cnt); end
`endif
    @(negedge clk);
    step();
    checks++;
    if (last_fire !== 1'b1 || last_addr !== RPC) begin
      errors++; $display("FAIL mid_restart: got fire=%b addr=%h expected fire=1 addr=%h", last_fire, last_addr, RPC);
    end
    repeat (6) step();
  endtask

  task automatic test_random();
    apply_reset();
    rsp_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset();
      bus.imem_req_ready = ($urandom_range(3) != 0);
      bus.out_ready      = ($urandom_range(2) != 0);
      mem_lat            = $urandom_range(4, 1);
      bus.redirect_valid = ($urandom_range(19) == 0);
      bus.redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      step();
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_ready_stall();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
